// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared FSM encoding, strobe constants and byte-merge helper
// used by the responder RTL and by the bench scoreboard.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SB0    = 4'b0001;
    localparam logic [3:0] SB1    = 4'b0010;
    localparam logic [3:0] SB2    = 4'b0100;
    localparam logic [3:0] SB3    = 4'b1000;
    localparam logic [3:0] SH_LO  = 4'b0011;
    localparam logic [3:0] SH_HI  = 4'b1100;
    localparam logic [3:0] SW_ALL = 4'b1111;

    localparam int LATENCY_MAX = 15;

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] wdata,
                                               input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i+:8] = strb[i] ? wdata[8*i+:8] : old_w[8*i+:8];
        return r;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: core data-port bundle between the M stage (master) and the
// memory responder (slave).
interface data_mem_responder_if;
    logic        mem_en;
    logic [3:0]  mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        mem_stall;
    logic        proto_err;

    modport master (
        output mem_en, mem_write_en, mem_addr, write_data,
        input  read_data, mem_stall, proto_err
    );

    modport slave (
        input  mem_en, mem_write_en, mem_addr, write_data,
        output read_data, mem_stall, proto_err
    );
endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// dmem_array: word-addressed 32-bit storage with combinational read and byte-lane
// writes on the rising edge; contents are never reset.
module dmem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [3:0]        i_wstrb,
    input  logic [31:0]       i_wdata
);
    logic [31:0] r_mem [2**ADDR_W];

    assign o_rdata = r_mem[i_raddr];

    always_ff @(posedge clk) begin
        if (i_we)
            for (int i = 0; i < 4; i++)
                if (i_wstrb[i]) r_mem[i_waddr][8*i+:8] <= i_wdata[8*i+:8];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: slow on-chip RAM model for the core data port; stalls each
// access for LATENCY cycles, commits writes on entry to DONE and flags protocol errors.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam bit         ZL     = (LATENCY == 0);
    localparam logic [3:0] LAT_M1 = ZL ? 4'd0 : 4'(LATENCY - 1);

    state_t            r_state, w_next_state;
    logic [3:0]        r_wait_cnt, w_next_cnt;
    logic [31:0]       r_req_addr, r_req_wdata, r_rdata;
    logic [3:0]        r_req_strb;
    logic              r_proto_err;
    logic              w_accept, w_mismatch, w_abort, w_go_done, w_from_bus, w_we, w_stall;
    logic [ADDR_W-1:0] w_acc_idx;
    logic [3:0]        w_acc_strb;
    logic [31:0]       w_acc_wdata, w_rdata;

    always_comb begin
        w_accept     = !ZL && r_state == IDLE && bus.mem_en;
        w_mismatch   = !bus.mem_en || bus.mem_addr != r_req_addr ||
                       bus.mem_write_en != r_req_strb || bus.write_data != r_req_wdata;
        w_abort      = r_state == WAIT && w_mismatch;
        w_go_done    = (w_accept && LATENCY == 1) ||
                       (r_state == WAIT && !w_mismatch && r_wait_cnt <= 4'd1);
        w_next_state = w_go_done ? DONE :
                       w_accept ? WAIT :
                       (r_state == WAIT && !w_abort) ? WAIT : IDLE;
        w_next_cnt   = w_accept ? LAT_M1 : (r_state == WAIT) ? r_wait_cnt - 4'd1 : r_wait_cnt;
        w_stall      = !ZL && (r_state == WAIT || (r_state == IDLE && bus.mem_en));
        // A LATENCY=1 access completes straight from IDLE, before req_* is loaded
        w_from_bus   = ZL || r_state == IDLE;
        w_acc_idx    = w_from_bus ? bus.mem_addr[ADDR_W+1:2] : r_req_addr[ADDR_W+1:2];
        w_acc_strb   = w_from_bus ? bus.mem_write_en : r_req_strb;
        w_acc_wdata  = w_from_bus ? bus.write_data : r_req_wdata;
        w_we         = (ZL ? bus.mem_en : w_go_done) && |w_acc_strb;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_wait_cnt  <= 4'd0;
            r_req_addr  <= '0;
            r_req_strb  <= '0;
            r_req_wdata <= '0;
            r_rdata     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_cnt;
            if (w_accept) begin
                r_req_addr  <= bus.mem_addr;
                r_req_strb  <= bus.mem_write_en;
                r_req_wdata <= bus.write_data;
            end
            if (w_go_done) r_rdata <= merge_word(w_rdata, w_acc_wdata, w_acc_strb);
            if (w_abort) r_proto_err <= 1'b1;
        end
    end

    dmem_array #(.ADDR_W(ADDR_W)) u_arr (
        .clk    (clk),
        .i_raddr(w_acc_idx),
        .o_rdata(w_rdata),
        .i_we   (w_we),
        .i_waddr(w_acc_idx),
        .i_wstrb(w_acc_strb),
        .i_wdata(w_acc_wdata)
    );

    assign bus.read_data = ZL ? w_rdata : r_rdata;
    assign bus.mem_stall = w_stall;
    assign bus.proto_err = r_proto_err;
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU core's data port.
- It accepts the M-stage request (mem_en, byte write strobes, byte address, write data) and returns read data.
- It holds the core with mem_stall for a programmable number of wait cycles, and emulates slow on-chip RAM for pipeline stall and hazard verification.
- It contains the word-addressed storage array with byte-lane writes.

Parameters:
- ADDR_W, 10, word-address bits; array holds 2**ADDR_W 32-bit words.
- LATENCY, 2, wait cycles per access, legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_en  in  1  request valid; held stable by the core while mem_stall=1.
- mem_write_en  in  4  byte strobes; bit i writes byte lane i; 4'b0000 with mem_en=1 is a read.
- mem_addr  in  32  byte address; word index = mem_addr[ADDR_W+1:2]; bits [1:0] and above ADDR_W+1 are ignored.
- write_data  in  32  lane-aligned store data.
- read_data  out  32  word read data.
- mem_stall  out  1  core must freeze M and earlier stages (feeds hazard stall inputs).
- proto_err  out  1  sticky flag: request dropped or changed while stalled.

Behaviour:
- FSM states are IDLE, WAIT and DONE, with a 4-bit wait_cnt.
- Reset (rst=0, any state):
  - state=IDLE, wait_cnt=0, read_data=0, mem_stall=0, proto_err=0.
  - An in-flight write is discarded.
  - Array contents are not reset.
- LATENCY=0:
  - The FSM stays in IDLE; mem_stall is never asserted.
  - read_data = array[idx], combinational, same cycle.
  - Writes commit at the rising edge while mem_en=1.
- LATENCY>=1, IDLE:
  - mem_stall = mem_en, combinational.
  - On an edge with mem_en=1: capture addr, strobes and wdata into req_* registers; wait_cnt=LATENCY-1; go to WAIT if LATENCY>1, else DONE.
- WAIT:
  - mem_stall=1.
  - Each edge decrements wait_cnt; go to DONE when wait_cnt==0.
- Transition into DONE (the edge):
  - Masked write commits to array[req_idx].
  - read_data register <= merged word (post-write contents for writes; plain word for reads).
- DONE:
  - mem_stall=0 for exactly one cycle; the core advances at the next edge.
  - The next edge always returns to IDLE. The request present during DONE is the completing one and is never re-accepted.
  - Back-to-back requests therefore occupy LATENCY+1 cycles each.
- read_data holds its value outside DONE (LATENCY>=1); it is valid only in DONE.
- Protocol check (WAIT state, LATENCY>=1):
  - If mem_en drops, or mem_addr/mem_write_en/write_data differ from req_*: set proto_err and abort to IDLE.
  - No write is committed and mem_stall deasserts.
  - proto_err clears only on reset.
- Byte merge: new_word[8i+7:8i] = strobe[i] ? write_data[8i+7:8i] : old[8i+7:8i].
- Partial strobes (sb 0001/0010/..., sh 0011/1100) need no special handling.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - the strobe constants SB0..SB3, SH_LO, SH_HI, SW_ALL;
  - the LATENCY_MAX=15 constant.
- One sub-module, dmem_array: 2**ADDR_W x 32 storage.
  - Interface: combinational read port, and a byte-strobed write port clocked on rising edge.
  - The responder FSM drives it.
- The merge function lives in the package so the bench scoreboard reuses it.

Test Plan:
- LATENCY=2, reset then read of addr 0x10 preloaded 0xDEADBEEF:
  - mem_stall=1 for 2 cycles, then DONE with mem_stall=0 and read_data=0xDEADBEEF; IDLE next cycle.
- LATENCY=2, sw 0x11223344 to 0x20, then lb-style read (strobe 0000) of 0x20:
  - The write's DONE read_data=0x11223344; the second request stalls 2 more cycles, then returns 0x11223344.
- Byte strobes on word 0xAABBCCDD:
  - Write strobe 0010 with data 0x0000EE00 -> word becomes 0xAABBEEDD.
  - Then strobe 1100 with data 0x12340000 -> word becomes 0x1234EEDD.
- LATENCY=3, assert rst low mid-WAIT during a store to 0x40 (old 0x0):
  - Outputs go to 0 immediately; state IDLE; a later read of 0x40 returns 0x00000000 (write discarded).
- LATENCY=2, drop mem_en in the first WAIT cycle:
  - proto_err=1 (sticky), mem_stall=0 next cycle, no array update; a following normal read still completes.
- LATENCY=0, back-to-back requests with write 0x5 to 0x8 then read 0x8 over consecutive cycles:
  - mem_stall never asserts; the read returns 0x00000005 combinationally in the second cycle.
